// File: rtl/onehot_pulse_decoder_if.sv
// Handshake and decode-output bundle for onehot_pulse_decoder.
// The master drives codes in; the slave (decoder) returns ready, status and the one-hot lines.
`timescale 1ns/1ps
interface onehot_pulse_decoder_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic [IN_W-1:0]  in_code;
  logic             in_ready;
  logic [OUT_W-1:0] out_onehot;
  logic             out_valid;
  logic             busy;
  logic             err;

  modport master (
    output in_valid, in_code,
    input  in_ready, out_onehot, out_valid, busy, err
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out_onehot, out_valid, busy, err
  );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Clocked 3-to-8 decoder: an accepted code drives its one-hot line for PULSE_LEN cycles,
// followed by GAP_LEN dead cycles before the next code is taken.
`timescale 1ns/1ps
module onehot_pulse_decoder #(
  parameter int IN_W      = 3,
  parameter int OUT_W     = 8,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_pulse_decoder_if.slave bus
);

  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? ((PULSE_LEN > 2) ? PULSE_LEN : 2)
                                                 : ((GAP_LEN > 2) ? GAP_LEN : 2);
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
  localparam logic [IN_W:0]    OUT_LIM  = (IN_W + 1)'(OUT_W);
  localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [OUT_W-1:0] r_onehot, w_onehot_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;
  logic             w_ready, w_busy, w_accept, w_code_ok;

  assign w_accept  = bus.in_valid && w_ready;
  assign w_code_ok = ({1'b0, bus.in_code} < OUT_LIM);

  // State register; the one-hot/valid/err outputs are registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_onehot <= w_onehot_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_onehot_nxt = r_onehot;
    w_valid_nxt  = r_valid;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_code_ok) begin
            w_state_nxt  = S_PULSE;
            w_cnt_nxt    = PULSE_LD;
            w_onehot_nxt = ONE << bus.in_code;
            w_valid_nxt  = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_onehot_nxt = '0;
          w_valid_nxt  = 1'b0;
          if (GAP_LEN > 0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (r_state == S_IDLE) && !rst;
    w_busy  = (r_state != S_IDLE);
  end

  assign bus.in_ready   = w_ready;
  assign bus.busy       = w_busy;
  assign bus.out_onehot = r_onehot;
  assign bus.out_valid  = r_valid;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder: default build, a 6-output build and a zero-gap build.
`timescale 1ns/1ps
module tb_onehot_pulse_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  onehot_pulse_decoder_if #(.IN_W(3), .OUT_W(8)) if0 ();
  onehot_pulse_decoder_if #(.IN_W(3), .OUT_W(6)) if1 ();
  onehot_pulse_decoder_if #(.IN_W(3), .OUT_W(8)) if2 ();

  onehot_pulse_decoder #(.IN_W(3), .OUT_W(8), .PULSE_LEN(4), .GAP_LEN(1)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  onehot_pulse_decoder #(.IN_W(3), .OUT_W(6), .PULSE_LEN(4), .GAP_LEN(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  onehot_pulse_decoder #(.IN_W(3), .OUT_W(8), .PULSE_LEN(4), .GAP_LEN(0)) u2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a code on u0, hold until accepted, then check the 4-cycle pulse and 1-cycle gap.
  task automatic do_pulse(input logic [2:0] code, input logic [7:0] exp);
    if0.in_valid = 1'b1;
    if0.in_code  = code;
    for (int i = 0; i < 16 && !if0.in_ready; i++) step();
    chk1("ready_before_accept", if0.in_ready, 1'b1);
    step();
    if0.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chkv("pulse_onehot", 32'(if0.out_onehot), 32'(exp));
      chk1("pulse_valid", if0.out_valid, 1'b1);
      chk1("pulse_err", if0.err, 1'b0);
      chk1("pulse_ready", if0.in_ready, 1'b0);
      if (i < 3) step();
    end
    step();
    chkv("gap_onehot", 32'(if0.out_onehot), 32'h0);
    chk1("gap_valid", if0.out_valid, 1'b0);
    chk1("gap_ready", if0.in_ready, 1'b0);
    chk1("gap_busy", if0.busy, 1'b1);
    step();
    chk1("idle_ready", if0.in_ready, 1'b1);
    chk1("idle_busy", if0.busy, 1'b0);
  endtask

  initial begin
    int vcnt;
    if0.in_valid = 1'b0; if0.in_code = '0;
    if1.in_valid = 1'b0; if1.in_code = '0;
    if2.in_valid = 1'b0; if2.in_code = '0;

    // Reset held for two edges
    rst = 1'b1;
    step();
    step();
    chkv("rst_onehot", 32'(if0.out_onehot), 32'h0);
    chk1("rst_valid", if0.out_valid, 1'b0);
    chk1("rst_err", if0.err, 1'b0);
    chk1("rst_ready", if0.in_ready, 1'b0);
    chk1("rst_busy", if0.busy, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rel_ready0", if0.in_ready, 1'b1);
    chk1("rel_ready1", if1.in_ready, 1'b1);
    chk1("rel_ready2", if2.in_ready, 1'b1);

    // Single decode of code 5
    do_pulse(3'd5, 8'h20);

    // Sweep all codes
    for (int unsigned c = 0; c < 8; c++) do_pulse(3'(c), sweep_exp[c]);

    // Out-of-range codes on the 6-output build
    if1.in_valid = 1'b1;
    if1.in_code  = 3'd7;
    step();
    chk1("oor_err", if1.err, 1'b1);
    chk1("oor_valid", if1.out_valid, 1'b0);
    chkv("oor_onehot", 32'(if1.out_onehot), 32'h0);
    chk1("oor_ready", if1.in_ready, 1'b1);
    chk1("oor_busy", if1.busy, 1'b0);
    if1.in_code = 3'd6;
    step();
    chk1("oor_b2b_err", if1.err, 1'b1);
    chk1("oor_b2b_valid", if1.out_valid, 1'b0);
    if1.in_valid = 1'b0;
    step();
    chk1("oor_err_clear", if1.err, 1'b0);
    if1.in_valid = 1'b1;
    if1.in_code  = 3'd5;
    step();
    if1.in_valid = 1'b0;
    chkv("w6_onehot", 32'(if1.out_onehot), 32'h20);
    chk1("w6_valid", if1.out_valid, 1'b1);
    chk1("w6_err", if1.err, 1'b0);

    // Backpressure: code 2 held through pulse and gap
    if0.in_valid = 1'b1;
    if0.in_code  = 3'd2;
    step();
    chkv("bp_onehot", 32'(if0.out_onehot), 32'h04);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("bp_hold_valid", if0.out_valid, 1'b1);
    end
    step();
    chk1("bp_gap_valid", if0.out_valid, 1'b0);
    chk1("bp_gap_ready", if0.in_ready, 1'b0);
    step();
    chk1("bp_idle_valid", if0.out_valid, 1'b0);
    chk1("bp_idle_ready", if0.in_ready, 1'b1);
    step();
    if0.in_valid = 1'b0;
    chkv("bp_re_onehot", 32'(if0.out_onehot), 32'h04);
    chk1("bp_re_valid", if0.out_valid, 1'b1);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if0.out_valid) vcnt++;
    end
    chkv("bp_single_pulse", 32'(vcnt), 32'd3);
    chk1("bp_end_busy", if0.busy, 1'b0);

    // Reset during the second pulse cycle
    if0.in_valid = 1'b1;
    if0.in_code  = 3'd1;
    step();
    if0.in_valid = 1'b0;
    chkv("mr_onehot1", 32'(if0.out_onehot), 32'h02);
    step();
    chk1("mr_valid2", if0.out_valid, 1'b1);
    rst = 1'b1;
    step();
    chkv("mr_onehot", 32'(if0.out_onehot), 32'h0);
    chk1("mr_valid", if0.out_valid, 1'b0);
    chk1("mr_busy", if0.busy, 1'b0);
    chk1("mr_ready_in_rst", if0.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("mr_ready", if0.in_ready, 1'b1);
    step();
    chk1("mr_no_resume", if0.out_valid, 1'b0);

    // Zero-gap build: IDLE follows the pulse directly
    if2.in_valid = 1'b1;
    if2.in_code  = 3'd3;
    step();
    chkv("g0_onehot", 32'(if2.out_onehot), 32'h08);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("g0_valid", if2.out_valid, 1'b1);
    end
    step();
    chk1("g0_idle_valid", if2.out_valid, 1'b0);
    chk1("g0_idle_ready", if2.in_ready, 1'b1);
    chk1("g0_idle_busy", if2.busy, 1'b0);
    step();
    if2.in_valid = 1'b0;
    chkv("g0_re_onehot", 32'(if2.out_onehot), 32'h08);
    chk1("g0_re_valid", if2.out_valid, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk1("g0_end_valid", if2.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
